// File: rtl/muldiv_issue_pkg.sv
// muldiv_issue_pkg: mul/div op codes, controller states and op-class helpers.
package muldiv_issue_pkg;
    localparam int MD_DW = 32;
    localparam int MD_OP_W = 4;
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL
    } md_op_e;
    typedef enum logic [2:0] {ST_IDLE, ST_MWAIT, ST_DWAIT, ST_ACC, ST_DONE} md_state_e;
    function automatic logic is_mul_op(logic [MD_OP_W-1:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL};
    endfunction
    function automatic logic is_div_op(logic [MD_OP_W-1:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction
    function automatic logic is_signed_op(logic [MD_OP_W-1:0] op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB, MD_MUL};
    endfunction
    function automatic logic is_acc_op(logic [MD_OP_W-1:0] op);
        return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction
    function automatic logic is_sub_op(logic [MD_OP_W-1:0] op);
        return op inside {MD_MSUB, MD_MSUBU};
    endfunction
endpackage

// File: rtl/muldiv_issue_acc.sv
// muldiv_acc: 2*DW modular add/sub of the latched {HI,LO} and the product.
module muldiv_acc #(
    parameter int W = 64
) (
    input  logic [W-1:0] hilo,
    input  logic [W-1:0] prod,
    input  logic         sub,
    output logic [W-1:0] sum
);
    assign sum = sub ? hilo - prod : hilo + prod;
endmodule

// File: rtl/muldiv_issue.sv
// muldiv_issue: EX-stage mul/div controller; launches the unit, stalls until ready, presents HI/LO or GPR write.
module muldiv_issue
    import muldiv_issue_pkg::*;
#(
    parameter int DW = MD_DW,
    parameter int OP_W = MD_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_stall_i,
    input  logic [OP_W-1:0] md_op_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic [DW-1:0]   hi_i,
    input  logic [DW-1:0]   lo_i,
    output logic            mul_start_o,
    output logic            mul_signed_o,
    output logic [DW-1:0]   mul_a_o,
    output logic [DW-1:0]   mul_b_o,
    input  logic [2*DW-1:0] mul_result_i,
    input  logic            mul_ready_i,
    output logic            div_start_o,
    output logic            div_signed_o,
    output logic [DW-1:0]   div_a_o,
    output logic [DW-1:0]   div_b_o,
    input  logic [2*DW-1:0] div_result_i,
    input  logic            div_ready_i,
    output logic            stallreq_o,
    output logic            whilo_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            wreg_md_o,
    output logic [DW-1:0]   wdata_md_o
);
    md_state_e state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [DW-1:0] a_q, b_q;
    logic sgn_q;
    logic [2*DW-1:0] hilo_q, res_q, acc_sum;
    logic en, idle, done, gpr, mul_op, div_op, b_zero, launch_mul, launch_div, div_zero, sgn;
    assign en = !rst && !flush;
    assign idle = state_q == ST_IDLE;
    assign done = en && state_q == ST_DONE;
    assign gpr = op_q == MD_MUL;
    assign mul_op = is_mul_op(md_op_i);
    assign div_op = is_div_op(md_op_i);
    assign b_zero = opdata2_i == '0;
    assign launch_mul = en && idle && mul_op;
    assign launch_div = en && idle && div_op && !b_zero;
    // Divide by zero never reaches the divider; its fixed result is formed here.
    assign div_zero = en && idle && div_op && b_zero;
    assign sgn = en && (idle ? is_signed_op(md_op_i) : sgn_q);
    muldiv_acc #(.W(2*DW)) u_acc (
        .hilo(hilo_q),
        .prod(res_q),
        .sub (is_sub_op(op_q)),
        .sum (acc_sum)
    );
    always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = ST_IDLE;
        else
            case (state_q)
                ST_IDLE:  state_d = launch_mul ? ST_MWAIT : launch_div ? ST_DWAIT : div_zero ? ST_DONE : ST_IDLE;
                ST_MWAIT: state_d = mul_ready_i ? (is_acc_op(op_q) ? ST_ACC : ST_DONE) : ST_MWAIT;
                ST_DWAIT: state_d = div_ready_i ? ST_DONE : ST_DWAIT;
                ST_ACC:   state_d = ST_DONE;
                ST_DONE:  state_d = ex_stall_i ? ST_DONE : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sgn_q <= 1'b0;
            hilo_q <= '0;
            res_q <= '0;
        end else begin
            if (launch_mul || launch_div || div_zero) begin
                op_q <= md_op_i;
                a_q <= opdata1_i;
                b_q <= opdata2_i;
                sgn_q <= is_signed_op(md_op_i);
                hilo_q <= {hi_i, lo_i};
            end
            if (div_zero) res_q <= {opdata1_i, {DW{1'b1}}};
            if (state_q == ST_MWAIT && mul_ready_i) res_q <= mul_result_i;
            if (state_q == ST_DWAIT && div_ready_i) res_q <= div_result_i;
            if (state_q == ST_ACC) res_q <= acc_sum;
        end
    end
    // Operands come straight from the inputs in the launch cycle, then from the latches.
    always_comb begin
        mul_start_o = launch_mul;
        div_start_o = launch_div;
        mul_signed_o = sgn;
        div_signed_o = sgn;
        mul_a_o = en ? (idle ? opdata1_i : a_q) : '0;
        mul_b_o = en ? (idle ? opdata2_i : b_q) : '0;
        div_a_o = mul_a_o;
        div_b_o = mul_b_o;
        stallreq_o = en && (idle ? (mul_op || div_op) : state_q != ST_DONE);
        whilo_o = done && !gpr;
        wreg_md_o = done && gpr;
        hi_o = done ? res_q[2*DW-1:DW] : '0;
        lo_o = done ? res_q[DW-1:0] : '0;
        wdata_md_o = (done && gpr) ? res_q[DW-1:0] : '0;
    end
endmodule

// File: tb/tb_muldiv_issue.sv
// tb_muldiv_issue: self-checking bench with behavioural mul/div unit responders and a spec-level result model.
module tb_muldiv_issue;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MADD = 4'd5, MADDU = 4'd6, MSUB = 4'd7, MSUBU = 4'd8, MUL = 4'd9;
    logic clk, rst, flush, ex_stall_i;
    logic [3:0] md_op_i;
    logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
    logic mul_start_o, mul_signed_o, div_start_o, div_signed_o;
    logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
    logic [63:0] mul_result_i, div_result_i;
    logic mul_ready_i, div_ready_i;
    logic stallreq_o, whilo_o, wreg_md_o;
    logic [31:0] hi_o, lo_o, wdata_md_o;
    int vectors, errors, lat, mul_cnt, div_cnt, mul_starts, div_starts;

    muldiv_issue dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall_i(ex_stall_i), .md_op_i(md_op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .wreg_md_o(wreg_md_o), .wdata_md_o(wdata_md_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one op: 64-bit {HI,LO}, or the full product for MUL.
    function automatic logic [63:0] ref_md(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] ps, pu;
        int sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        sq = 0;
        sr = 0;
        if (op == DIV && b != 0) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
        end
        case (op)
            MULT, MUL: return ps;
            MULTU:     return pu;
            MADD:      return hilo + ps;
            MADDU:     return hilo + pu;
            MSUB:      return hilo - ps;
            MSUBU:     return hilo - pu;
            DIV:       return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sr), 32'(sq)};
            DIVU:      return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:   return 64'd0;
        endcase
    endfunction

    // Unit responders: ready pulses lat cycles after the launch cycle; they ignore flush.
    always @(posedge clk) begin
        if (rst) begin
            mul_ready_i <= 1'b0;
            div_ready_i <= 1'b0;
            mul_cnt <= 0;
            div_cnt <= 0;
            mul_starts <= 0;
            div_starts <= 0;
            mul_result_i <= '0;
            div_result_i <= '0;
        end else begin
            mul_ready_i <= mul_cnt == 1;
            div_ready_i <= div_cnt == 1;
            if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
            if (div_cnt > 0) div_cnt <= div_cnt - 1;
            if (mul_start_o) begin
                mul_starts <= mul_starts + 1;
                mul_result_i <= ref_md(mul_signed_o ? MULT : MULTU, mul_a_o, mul_b_o, 64'd0);
                if (lat == 1) mul_ready_i <= 1'b1;
                else mul_cnt <= lat - 1;
            end
            if (div_start_o) begin
                div_starts <= div_starts + 1;
                div_result_i <= ref_md(div_signed_o ? DIV : DIVU, div_a_o, div_b_o, 64'd0);
                if (lat == 1) div_ready_i <= 1'b1;
                else div_cnt <= lat - 1;
            end
        end
    end

    // Present one op and hold it until a write appears; stalls = -1 if none within the budget.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input int k,
                         output int stalls, output logic [63:0] res, output logic wh,
                         output logic wr, output logic [31:0] wd, output logic sg);
        logic fin;
        lat = k;
        @(posedge clk);
        #1;
        md_op_i = op;
        opdata1_i = a;
        opdata2_i = b;
        hi_i = h;
        lo_i = l;
        stalls = 0;
        res = 'x;
        wh = 1'b0;
        wr = 1'b0;
        wd = 'x;
        sg = 1'bx;
        fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) sg = mul_start_o ? mul_signed_o : div_signed_o;
            if (stallreq_o) stalls++;
            if (whilo_o || wreg_md_o) begin
                res = {hi_o, lo_o};
                wh = whilo_o;
                wr = wreg_md_o;
                wd = wdata_md_o;
                fin = 1'b1;
            end
        end
        if (!fin) stalls = -1;
    endtask

    task automatic idle_cycle;
        @(posedge clk);
        #1;
        md_op_i = NONE;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        md_op_i = MULT;
        opdata1_i = 32'd5;
        opdata2_i = 32'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mul_start_o, mul_signed_o, div_start_o, div_signed_o, stallreq_o, whilo_o, wreg_md_o,
             hi_o, lo_o, wdata_md_o, mul_a_o, mul_b_o, div_a_o, div_b_o} !== '0)
            begin errors++; $display("FAIL reset_outputs: stall=%b whilo=%b hi=%h lo=%h a=%h, all must be 0", stallreq_o, whilo_o, hi_o, lo_o, mul_a_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        md_op_i = NONE;
        @(negedge clk);
        vectors++;
        if ({mul_start_o, div_start_o, stallreq_o, whilo_o, wreg_md_o} !== 5'b0)
            begin errors++; $display("FAIL idle_none: start=%b/%b stall=%b whilo=%b wreg=%b, required all 0", mul_start_o, div_start_o, stallreq_o, whilo_o, wreg_md_o); end
    endtask

    task automatic test_mult;
        int st, m0;
        logic [63:0] r;
        logic wh, wr, sg;
        logic [31:0] wd;
        m0 = mul_starts;
        issue(MULT, 32'hFFFF_FFF9, 32'd3, 32'd0, 32'd0, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if (st !== 3) begin errors++; $display("FAIL mult_stall: got %0d cycles, required 3", st); end
        vectors++;
        if ({wh, wr, r} !== {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB})
            begin errors++; $display("FAIL mult_result: whilo=%b wreg=%b hilo=%h, required 1 0 ffffffffffffffeb", wh, wr, r); end
        vectors++;
        if (sg !== 1'b1) begin errors++; $display("FAIL mult_signed: got %b, required 1", sg); end
        m0 = mul_starts - m0;
        vectors++;
        if (m0 !== 1) begin errors++; $display("FAIL mult_launches: got %0d, required 1", m0); end
        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if ({wh, r} !== {1'b1, 64'h0000_0001_FFFF_FFFE})
            begin errors++; $display("FAIL multu_result: whilo=%b hilo=%h, required 1 00000001fffffffe", wh, r); end
        vectors++;
        if (sg !== 1'b0) begin errors++; $display("FAIL multu_signed: got %b, required 0", sg); end
    endtask

    task automatic test_madd_msub;
        int st;
        logic [63:0] r;
        logic wh, wr, sg;
        logic [31:0] wd;
        issue(MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if ({st, wh, r} !== {32'd4, 1'b1, 64'h0000_0001_0000_0000})
            begin errors++; $display("FAIL madd: stall=%0d whilo=%b hilo=%h, required 4 1 0000000100000000", st, wh, r); end
        issue(MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if ({st, wh, r} !== {32'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF})
            begin errors++; $display("FAIL msub: stall=%0d whilo=%b hilo=%h, required 4 1 ffffffffffffffff", st, wh, r); end
    endtask

    task automatic test_div;
        int st, d0;
        logic [63:0] r;
        logic wh, wr, sg;
        logic [31:0] wd;
        d0 = div_starts;
        issue(DIV, 32'd7, 32'd0, 32'd0, 32'd0, 2, st, r, wh, wr, wd, sg);
        d0 = div_starts - d0;
        vectors++;
        if ({st, wh, r} !== {32'd1, 1'b1, 64'h0000_0007_FFFF_FFFF})
            begin errors++; $display("FAIL div_zero: stall=%0d whilo=%b hilo=%h, required 1 1 00000007ffffffff", st, wh, r); end
        vectors++;
        if (d0 !== 0) begin errors++; $display("FAIL div_zero_launch: got %0d launches, required 0", d0); end
        d0 = div_starts;
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 3, st, r, wh, wr, wd, sg);
        d0 = div_starts - d0;
        vectors++;
        if ({st, wh, r} !== {32'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD})
            begin errors++; $display("FAIL div_signed: stall=%0d whilo=%b hilo=%h, required 4 1 fffffffffffffffd", st, wh, r); end
        vectors++;
        if (d0 !== 1) begin errors++; $display("FAIL div_launch: got %0d launches, required 1", d0); end
    endtask

    task automatic test_flush;
        int m0;
        m0 = mul_starts;
        lat = 4;
        @(posedge clk);
        #1;
        md_op_i = MULT;
        opdata1_i = 32'd3;
        opdata2_i = 32'd5;
        @(negedge clk);
        vectors++;
        if ({stallreq_o, mul_start_o} !== 2'b11) begin errors++; $display("FAIL flush_launch: stall,start=%b, required 11", {stallreq_o, mul_start_o}); end
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stallreq_o, mul_start_o, whilo_o, wreg_md_o, hi_o, lo_o} !== '0)
            begin errors++; $display("FAIL flush_outputs: stall=%b whilo=%b hi=%h lo=%h, required all 0", stallreq_o, whilo_o, hi_o, lo_o); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        md_op_i = NONE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({stallreq_o, mul_start_o, whilo_o, wreg_md_o} !== 4'b0)
                begin errors++; $display("FAIL flush_after[%0d]: stall=%b start=%b whilo=%b wreg=%b, required 0", c, stallreq_o, mul_start_o, whilo_o, wreg_md_o); end
        end
        m0 = mul_starts - m0;
        vectors++;
        if (m0 !== 1) begin errors++; $display("FAIL flush_launches: got %0d, required 1", m0); end
    endtask

    task automatic test_ex_stall;
        int st, m0;
        logic [63:0] r, exp;
        logic wh, wr, sg;
        logic [31:0] wd;
        m0 = mul_starts;
        exp = ref_md(MULTU, 32'h0001_2345, 32'h0000_0100, 64'd0);
        ex_stall_i = 1'b1;
        issue(MULTU, 32'h0001_2345, 32'h0000_0100, 32'd0, 32'd0, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if ({wh, r} !== {1'b1, exp}) begin errors++; $display("FAIL stall_result: whilo=%b hilo=%h, required 1 %h", wh, r, exp); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({whilo_o, hi_o, lo_o, stallreq_o, mul_start_o} !== {1'b1, exp, 2'b00})
                begin errors++; $display("FAIL stall_hold[%0d]: whilo=%b hilo=%h stall=%b start=%b, required 1 %h 0 0", c, whilo_o, {hi_o, lo_o}, stallreq_o, mul_start_o, exp); end
        end
        @(posedge clk);
        #1;
        ex_stall_i = 1'b0;
        md_op_i = NONE;
        @(negedge clk);
        @(negedge clk);
        m0 = mul_starts - m0;
        vectors++;
        if ({whilo_o, stallreq_o, m0} !== {2'b00, 32'd1})
            begin errors++; $display("FAIL stall_release: whilo=%b stall=%b launches=%0d, required 0 0 1", whilo_o, stallreq_o, m0); end
    endtask

    task automatic test_mul_gpr;
        int st;
        logic [63:0] r;
        logic wh, wr, sg;
        logic [31:0] wd;
        issue(MUL, 32'd5, 32'd6, 32'hDEAD_BEEF, 32'h1234_5678, 2, st, r, wh, wr, wd, sg);
        vectors++;
        if ({st, wh, wr, wd} !== {32'd3, 1'b0, 1'b1, 32'd30})
            begin errors++; $display("FAIL mul_gpr: stall=%0d whilo=%b wreg=%b wdata=%0d, required 3 0 1 30", st, wh, wr, wd); end
    endtask

    task automatic test_back_to_back;
        int st, k, m0, d0, em, ed, es;
        logic [3:0] op;
        logic [31:0] a, b, h, l, wd;
        logic [63:0] r, exp;
        logic wh, wr, sg;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(1, 9));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd1;
            h = $urandom;
            l = $urandom;
            k = $urandom_range(1, 5);
            exp = ref_md(op, a, b, {h, l});
            em = (op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL}) ? 1 : 0;
            ed = (op inside {DIV, DIVU} && b != 0) ? 1 : 0;
            es = (op inside {DIV, DIVU} && b == 0) ? 1 : k + 1 + ((op inside {MADD, MADDU, MSUB, MSUBU}) ? 1 : 0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
            m0 = mul_starts;
            d0 = div_starts;
            issue(op, a, b, h, l, k, st, r, wh, wr, wd, sg);
            m0 = mul_starts - m0;
            d0 = div_starts - d0;
            vectors++;
            if (st !== es) begin errors++; $display("FAIL rand_stall[%0d] op=%0d: got %0d, required %0d", n, op, st, es); end
            vectors++;
            if (op == MUL) begin
                if ({wh, wr, wd} !== {2'b01, exp[31:0]})
                    begin errors++; $display("FAIL rand_gpr[%0d]: whilo=%b wreg=%b wdata=%h, required 0 1 %h", n, wh, wr, wd, exp[31:0]); end
            end else if ({wh, wr, r} !== {2'b10, exp})
                begin errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: whilo=%b wreg=%b hilo=%h, required 1 0 %h", n, op, a, b, wh, wr, r, exp); end
            vectors++;
            if ({m0, d0} !== {em, ed}) begin errors++; $display("FAIL rand_launch[%0d] op=%0d: mul=%0d div=%0d, required %0d %0d", n, op, m0, d0, em, ed); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        errors = 0;
        lat = 2;
        rst = 1'b1;
        flush = 1'b0;
        ex_stall_i = 1'b0;
        md_op_i = NONE;
        opdata1_i = '0;
        opdata2_i = '0;
        hi_i = '0;
        lo_i = '0;
        test_reset();
        test_mult();
        test_madd_msub();
        test_div();
        idle_cycle();
        test_flush();
        test_ex_stall();
        test_mul_gpr();
        test_back_to_back();
        idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
